// File: rtl/prism_cfg_pkg.sv
// Shared definitions for the PRISM configuration sequencer.
//   state_t    : sequencer state (encoding is visible in the CTRL/STAT read)
//   ADDR_*     : host register addresses owned by the sequencer
//   CTRL_*     : bit positions inside a CTRL write
//   cfg_word_t : one queued configuration word {debug addr, debug data}
package prism_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } state_t;

  localparam logic [5:0] ADDR_CTRL  = 6'h34;
  localparam logic [5:0] ADDR_STAGE = 6'h38;
  localparam logic [5:0] ADDR_PUSH  = 6'h3C;

  localparam int CTRL_GO      = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_CLR_OVF = 30;
  localparam int CTRL_CLR_IRQ = 31;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } cfg_word_t;

endpackage

// File: rtl/prism_cfg_fifo.sv
// 38-bit synchronous FIFO holding queued configuration words.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : empties the FIFO (wins over push/pop)
//   push/wdata : enqueue, ignored while full
//   pop/rdata  : dequeue; rdata is the current head (valid when !empty)
//   full/empty/count : occupancy, count runs 0..DEPTH
module prism_cfg_fifo
  import prism_cfg_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  cfg_word_t       wdata,
  input  logic            pop,
  output cfg_word_t       rdata,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count
);

  cfg_word_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/prism_cfg_seq.sv
// Configuration sequencer and debug-bus arbiter in front of PRISM.
// The host queues {addr,data} words, issues GO; the block holds PRISM in
// debug reset, drains the queue onto the debug write port, releases reset,
// enables the FSM and raises irq when PRISM halts. Host passthrough
// accesses share the debug port and always win.
//   clk, rst_n        : clock, synchronous active-low reset
//   address/data_in/data_write_n/data_out/data_ready : host bus
//   dbg_addr/dbg_wr/dbg_wdata/dbg_rdata              : PRISM debug port
//   prism_reset/prism_enable/prism_halt              : PRISM control
//   irq               : level done interrupt
module prism_cfg_seq
  import prism_cfg_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic [5:0]  dbg_addr,
  output logic        dbg_wr,
  output logic [31:0] dbg_wdata,
  input  logic [31:0] dbg_rdata,
  output logic        prism_reset,
  output logic        prism_enable,
  input  logic        prism_halt,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  state_t          state, state_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic            rst_nxt, en_nxt, irq_set;
  logic            ovf, halt_q;
  logic [5:0]      stage_addr;

  logic            host_wr, is_ctrl, is_stage, is_push, pass_wr;
  logic            go, abort, push_req, push_ok, pop, drained;
  cfg_word_t       f_head;
  logic            f_full, f_empty;
  logic [AW:0]     f_count, cnt_after;

  assign data_ready = 1'b1;

  assign host_wr  = (data_write_n == 2'b10);
  assign is_ctrl  = (address == ADDR_CTRL);
  assign is_stage = (address == ADDR_STAGE);
  assign is_push  = (address == ADDR_PUSH);
  assign pass_wr  = host_wr && !is_ctrl && !is_stage && !is_push;
  assign go       = host_wr && is_ctrl && data_in[CTRL_GO];
  assign abort    = host_wr && is_ctrl && data_in[CTRL_ABORT];
  assign push_req = host_wr && is_push;
  assign push_ok  = push_req && !f_full;

  // A host passthrough write owns the port; the load word waits a cycle.
  assign pop = (state == ST_LOAD) && !f_empty && !pass_wr && !abort;

  // Occupancy after this cycle's push/pop decides whether loading is done,
  // so RELEASE follows the last load write directly.
  assign cnt_after = f_count + (AW+1)'(push_ok) - (AW+1)'(pop);
  assign drained   = (cnt_after == '0);

  assign dbg_wr    = pass_wr || pop;
  assign dbg_addr  = pop ? f_head.addr : address;
  assign dbg_wdata = pop ? f_head.data : data_in;

  prism_cfg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (push_req),
    .wdata ('{addr: stage_addr, data: data_in}),
    .pop   (pop),
    .rdata (f_head),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  always_comb begin
    data_out = dbg_rdata;
    if (is_ctrl)       data_out = {irq, ovf, 22'b0, 5'(f_count), state};
    else if (is_stage) data_out = {26'b0, stage_addr};
    else if (is_push)  data_out = 32'b0;
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    rst_nxt   = prism_reset;
    en_nxt    = prism_enable;
    irq_set   = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
      rst_nxt   = 1'b0;
      en_nxt    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (go) begin
          state_nxt = ST_HOLD;
          hold_nxt  = '0;
          rst_nxt   = 1'b1;
          en_nxt    = 1'b0;
        end
        ST_HOLD: begin
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            // An empty queue skips LOAD entirely.
            if (drained) begin
              state_nxt = ST_RELEASE;
              rst_nxt   = 1'b0;
            end else begin
              state_nxt = ST_LOAD;
            end
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        ST_LOAD: if (drained) begin
          state_nxt = ST_RELEASE;
          rst_nxt   = 1'b0;
        end
        ST_RELEASE: begin
          state_nxt = ST_RUN;
          en_nxt    = 1'b1;
        end
        ST_RUN: if (prism_halt && !halt_q) begin
          state_nxt = ST_IDLE;
          irq_set   = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      hold_cnt     <= '0;
      prism_reset  <= 1'b0;
      prism_enable <= 1'b0;
      irq          <= 1'b0;
      ovf          <= 1'b0;
      halt_q       <= 1'b0;
      stage_addr   <= '0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_nxt;
      prism_reset  <= rst_nxt;
      prism_enable <= en_nxt;
      halt_q       <= prism_halt;
      // Set wins over a clear in the same cycle for both sticky flags.
      irq <= irq_set || (irq && !(host_wr && is_ctrl && data_in[CTRL_CLR_IRQ]));
      ovf <= (push_req && f_full) ||
             (ovf && !(host_wr && is_ctrl && data_in[CTRL_CLR_OVF]));
      if (host_wr && is_stage) stage_addr <= data_in[5:0];
    end
  end

endmodule
